sim_spi_ram: RTL and testbench
==============================

SIM_SPI_RAM -- requirements
Module: sim_spi_ram

Interface
REQ-001 Parameter INIT_FILE, default "" ; hex image loaded into memory at time zero; empty string leaves memory all-zero.
REQ-002 Parameter DEPTH, default 65536; memory size in bytes, power of two.
REQ-003 spi_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset, sampled on spi_clk rising edge.
REQ-005 spi_select  input  1  chip select, active-high; 0 = deselected.
REQ-006 spi_mosi  input  1  serial command/address/data in, MSB first.
REQ-007 spi_miso  output  1  serial read data out, MSB first.
REQ-008 debug_clk  input  1  kept for port compatibility; no functional effect.
REQ-009 debug_addr  input  24  byte address for backdoor read.
REQ-010 debug_data  output  32  backdoor read word.

Function
REQ-011 Memory SHALL be DEPTH bytes; all addresses reduced modulo DEPTH (wrap-around, no error).
REQ-012 Memory SHALL be initialised once from INIT_FILE via hex load, one byte per entry, entry 0 at address 0.
REQ-013 States SHALL be CMD, ADDR, READ, WRITE, IGNORE.
REQ-014 Each spi_clk rising edge with spi_select=1 SHALL shift spi_mosi into an 8-bit shift register and advance a bit counter.
REQ-015 In CMD, after 8 bits: 0x03 -> ADDR (read), 0x02 -> ADDR (write), any other value -> IGNORE.
REQ-016 In ADDR, the next 24 bits form the start address, MSB first; after bit 24 go to READ or WRITE per command.
REQ-017 READ: on the edge completing address bit 24, spi_miso SHALL present bit 7 of mem[addr]; each later edge presents the next bit; after bit 0, continue with bit 7 of mem[addr+1], indefinitely (sequential mode).
REQ-018 Host samples spi_miso on the rising edge following the one that launched it (SPI mode 0 timing, launch on same edge the slave updates).
REQ-019 WRITE: every 8 bits received SHALL be stored to mem[addr] on the 8th bit's edge; addr then increments modulo DEPTH.
REQ-020 Incomplete trailing write byte at deselect SHALL be discarded.
REQ-021 IGNORE: consume bits, no memory change, spi_miso=0.
REQ-022 Any rising edge with spi_select=0 SHALL return to CMD, clear bit counter and shift register, drive spi_miso=0; data already written stays.
REQ-023 Host SHALL supply at least one spi_clk rising edge with spi_select=0 between transactions.
REQ-024 spi_miso SHALL be 0 in every state other than READ.
REQ-025 debug_data SHALL be combinational, big-endian: {mem[a], mem[a+1], mem[a+2], mem[a+3]}, a = debug_addr mod DEPTH, each increment wrapping.
REQ-026 debug_data SHALL reflect a SPI write in the same time step as the storing edge.
REQ-027 SPI write and backdoor read of the same byte simultaneously: debug_data shows new value after the edge.

Reset
REQ-028 rst=1 on a rising edge SHALL set state CMD, bit counter 0, shift register 0, address 0, spi_miso 0.
REQ-029 Reset SHALL NOT alter memory contents.
REQ-030 Reset mid-transaction SHALL abort it; the next transaction starts at a command byte regardless of spi_select.

Verification
REQ-031 INIT_FILE bytes 12 34 56 78 at 0..3; debug_addr=0 -> debug_data=0x12345678.
REQ-032 Select, send 0x03, addr 0x000000, clock 16 bits -> MISO yields 0x12, 0x34.
REQ-033 Send 0x02, addr 0x000010, bytes 0xAB 0xCD; deselect -> debug_addr=0x10 gives 0xABCDxxxx; read back via SPI returns 0xAB 0xCD.
REQ-034 Read from addr DEPTH-1 for 2 bytes -> mem[DEPTH-1] then mem[0].
REQ-035 Command 0x05 then 32 clocks -> MISO stays 0, memory unchanged.
REQ-036 Assert rst after 12 bits of a write command -> no memory change; fresh 0x03 read then succeeds.

Source files
------------

// File: rtl/sim_spi_ram.sv
// Behavioural SPI byte-RAM slave (0x03 read / 0x02 write, 24-bit address,
// sequential streaming) with a combinational big-endian backdoor read port.
module sim_spi_ram #(
  parameter string INIT_FILE = "",
  parameter int    DEPTH     = 65536
) (
  input  logic        spi_clk,
  input  logic        rst,
  input  logic        spi_select,
  input  logic        spi_mosi,
  output logic        spi_miso,
  input  logic        debug_clk,
  input  logic [23:0] debug_addr,
  output logic [31:0] debug_data
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    ST_CMD,
    ST_ADDR,
    ST_READ,
    ST_WRITE,
    ST_IGNORE
  } state_t;

  logic [7:0]    mem [DEPTH];
  state_t        state;
  logic [4:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic [23:0]   addr;
  logic          is_write;
  logic [7:0]    shift_in;
  logic [23:0]   addr_in;
  logic [AW-1:0] da;
  logic          unused_bits;

  // Memory image: zero-filled.
  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  assign shift_in = {shift_reg[6:0], spi_mosi};
  assign addr_in  = {addr[22:0], spi_mosi};

  // debug_clk has no function; upper address bits are dropped by the modulo.
  assign unused_bits = &{1'b0, debug_clk, debug_addr, addr, shift_reg[7]};

  // Protocol FSM: command decode, address capture, streaming read/write.
  // In READ, bit_cnt holds the index of the next bit to launch on spi_miso.
  always_ff @(posedge spi_clk) begin
    if (rst || !spi_select) begin
      state     <= ST_CMD;
      bit_cnt   <= '0;
      shift_reg <= '0;
      spi_miso  <= 1'b0;
      is_write  <= 1'b0;
      if (rst) addr <= '0;
    end else begin
      shift_reg <= shift_in;
      spi_miso  <= 1'b0;
      bit_cnt   <= bit_cnt + 5'd1;
      case (state)
        ST_CMD: begin
          if (bit_cnt == 5'd7) begin
            bit_cnt <= '0;
            if (shift_in == 8'h03) begin
              state    <= ST_ADDR;
              is_write <= 1'b0;
            end else if (shift_in == 8'h02) begin
              state    <= ST_ADDR;
              is_write <= 1'b1;
            end else begin
              state <= ST_IGNORE;
            end
          end
        end
        ST_ADDR: begin
          addr <= addr_in;
          if (bit_cnt == 5'd23) begin
            if (is_write) begin
              state   <= ST_WRITE;
              bit_cnt <= '0;
            end else begin
              state    <= ST_READ;
              bit_cnt  <= 5'd6;
              spi_miso <= mem[addr_in[AW-1:0]][7];
            end
          end
        end
        ST_READ: begin
          spi_miso <= mem[addr[AW-1:0]][bit_cnt[2:0]];
          if (bit_cnt == 5'd0) begin
            bit_cnt <= 5'd7;
            addr    <= addr + 24'd1;
          end else begin
            bit_cnt <= bit_cnt - 5'd1;
          end
        end
        ST_WRITE: begin
          if (bit_cnt == 5'd7) begin
            mem[addr[AW-1:0]] <= shift_in;
            addr              <= addr + 24'd1;
            bit_cnt           <= '0;
          end
        end
        ST_IGNORE: ;
        default: state <= ST_CMD;
      endcase
    end
  end

  // Backdoor big-endian word read, each byte address wrapping independently.
  always_comb begin
    da         = debug_addr[AW-1:0];
    debug_data = {mem[da], mem[da + AW'(1)], mem[da + AW'(2)], mem[da + AW'(3)]};
  end

endmodule

// File: tb/tb_sim_spi_ram.sv
// Randomised self-checking bench for sim_spi_ram against a byte-array model.
module tb_sim_spi_ram;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        dclk = 1'b0;
  logic        rst;
  logic        sel;
  logic        mosi;
  logic        miso;
  logic [23:0] daddr;
  logic [31:0] ddata;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [DEPTH];
  logic [7:0] rd_buf [$];
  logic       pre_nz;

  sim_spi_ram #(.INIT_FILE(""), .DEPTH(DEPTH)) dut (
    .spi_clk(clk), .rst(rst), .spi_select(sel), .spi_mosi(mosi),
    .spi_miso(miso), .debug_clk(dclk), .debug_addr(daddr), .debug_data(ddata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_debug(input logic [23:0] a);
    int unsigned b;
    b = int'(a) % DEPTH;
    return {ref_mem[b], ref_mem[(b + 1) % DEPTH], ref_mem[(b + 2) % DEPTH],
            ref_mem[(b + 3) % DEPTH]};
  endfunction

  // Drive one bit before the next rising edge; return miso launched by the previous edge.
  task automatic send_bit(input logic b, output logic o);
    @(negedge clk);
    o    = miso;
    sel  = 1'b1;
    mosi = b;
  endtask

  task automatic send_byte(input logic [7:0] v, output logic [7:0] o);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      send_bit(v[i], b);
      o[i] = b;
    end
  endtask

  task automatic deselect();
    @(negedge clk);
    sel  = 1'b0;
    mosi = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
    logic [7:0] o;
    send_byte(cmd, o);     pre_nz = pre_nz | (|o);
    send_byte(a[23:16], o); pre_nz = pre_nz | (|o);
    send_byte(a[15:8], o);  pre_nz = pre_nz | (|o);
    send_byte(a[7:0], o);   pre_nz = pre_nz | (|o);
  endtask

  task automatic spi_write(input logic [23:0] a, input logic [7:0] d [$]);
    logic [7:0] o;
    pre_nz = 1'b0;
    send_hdr(8'h02, a);
    foreach (d[i]) begin
      send_byte(d[i], o);
      ref_mem[(int'(a) + i) % DEPTH] = d[i];
    end
    deselect();
  endtask

  task automatic spi_read(input logic [23:0] a, input int n);
    logic [7:0] o;
    rd_buf.delete();
    pre_nz = 1'b0;
    send_hdr(8'h03, a);
    for (int i = 0; i < n; i++) begin
      send_byte(8'($urandom), o);
      rd_buf.push_back(o);
    end
    deselect();
  endtask

  task automatic test_reset();
    rst = 1'b1; sel = 1'b0; mosi = 1'b0; daddr = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b want 0", miso); end
    checks++;
    if (ddata !== 32'h0) begin errors++; $display("FAIL reset_mem got %h want 00000000", ddata); end
    rst = 1'b0;
    deselect();
  endtask

  task automatic test_write_init();
    logic [7:0] o;
    logic [7:0] vals [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    daddr = 24'h0;
    pre_nz = 1'b0;
    send_hdr(8'h02, 24'h0);
    for (int i = 0; i < 4; i++) begin
      send_byte(vals[i], o);
      @(posedge clk);
      #1;
      ref_mem[i] = vals[i];
      checks++;
      if (ddata !== ref_debug(24'h0)) begin
        errors++; $display("FAIL same_step_debug byte %0d got %h want %h", i, ddata, ref_debug(24'h0));
      end
    end
    deselect();
    checks++;
    if (ddata !== 32'h12345678) begin errors++; $display("FAIL init_word got %h want 12345678", ddata); end
  endtask

  task automatic test_read_basic();
    spi_read(24'h0, 2);
    checks++;
    if (rd_buf[0] !== 8'h12 || rd_buf[1] !== 8'h34) begin
      errors++; $display("FAIL read_basic got %h %h want 12 34", rd_buf[0], rd_buf[1]);
    end
    checks++;
    if (pre_nz !== 1'b0) begin errors++; $display("FAIL read_hdr_miso got %b want 0", pre_nz); end
  endtask

  task automatic test_write_readback();
    spi_write(24'h000010, '{8'hAB, 8'hCD});
    daddr = 24'h10;
    #1;
    checks++;
    if (ddata[31:16] !== 16'hABCD) begin errors++; $display("FAIL wr_debug got %h want abcd", ddata[31:16]); end
    spi_read(24'h000010, 2);
    checks++;
    if (rd_buf[0] !== 8'hAB || rd_buf[1] !== 8'hCD) begin
      errors++; $display("FAIL wr_readback got %h %h want ab cd", rd_buf[0], rd_buf[1]);
    end
  endtask

  task automatic test_wrap();
    spi_write(24'(DEPTH - 1), '{8'($urandom), 8'($urandom)});
    spi_read(24'(DEPTH - 1), 2);
    checks++;
    if (rd_buf[0] !== ref_mem[DEPTH-1] || rd_buf[1] !== ref_mem[0]) begin
      errors++; $display("FAIL wrap_read got %h %h want %h %h", rd_buf[0], rd_buf[1], ref_mem[DEPTH-1], ref_mem[0]);
    end
    daddr = 24'(DEPTH - 2);
    #1;
    checks++;
    if (ddata !== ref_debug(daddr)) begin errors++; $display("FAIL wrap_debug got %h want %h", ddata, ref_debug(daddr)); end
    daddr = 24'hFFFFFF;
    #1;
    checks++;
    if (ddata !== ref_debug(daddr)) begin errors++; $display("FAIL high_addr_debug got %h want %h", ddata, ref_debug(daddr)); end
    spi_read(24'hABCD00 | 24'(DEPTH - 1), 1);
    checks++;
    if (rd_buf[0] !== ref_mem[DEPTH-1]) begin
      errors++; $display("FAIL high_addr_read got %h want %h", rd_buf[0], ref_mem[DEPTH-1]);
    end
  endtask

  task automatic sweep_mem(input string tag);
    for (int a = 0; a < DEPTH; a += 4) begin
      daddr = 24'(a);
      #1;
      checks++;
      if (ddata !== ref_debug(daddr)) begin
        errors++; $display("FAIL %s addr %0d got %h want %h", tag, a, ddata, ref_debug(daddr));
      end
    end
  endtask

  task automatic test_ignore();
    logic [7:0] cmds [3];
    logic [7:0] o;
    logic       nz;
    cmds[0] = 8'h05;
    for (int k = 1; k < 3; k++) begin
      do cmds[k] = 8'($urandom); while (cmds[k] == 8'h02 || cmds[k] == 8'h03);
    end
    for (int k = 0; k < 3; k++) begin
      nz = 1'b0;
      send_byte(cmds[k], o);
      for (int i = 0; i < 4; i++) begin
        send_byte(8'($urandom), o);
        nz = nz | (|o);
      end
      deselect();
      checks++;
      if (nz !== 1'b0) begin errors++; $display("FAIL ignore_miso cmd %h got %b want 0", cmds[k], nz); end
    end
    sweep_mem("ignore_mem");
  endtask

  task automatic test_partial();
    logic [7:0]  o;
    logic        b;
    logic [23:0] a;
    logic [7:0]  d;
    a = 24'($urandom);
    d = 8'($urandom);
    pre_nz = 1'b0;
    send_hdr(8'h02, a);
    send_byte(d, o);
    ref_mem[int'(a) % DEPTH] = d;
    for (int i = 0; i < 5; i++) send_bit(~ref_mem[(int'(a) + 1) % DEPTH][7 - i], b);
    deselect();
    daddr = a;
    #1;
    checks++;
    if (ddata !== ref_debug(a)) begin errors++; $display("FAIL partial_byte got %h want %h", ddata, ref_debug(a)); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] o;
    logic       b;
    send_byte(8'h02, o);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom), b);
    @(negedge clk);
    rst = 1'b1; sel = 1'b1; mosi = 1'($urandom);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (miso !== 1'b0) begin errors++; $display("FAIL midrst_miso got %b want 0", miso); end
    spi_read(24'h000000, 4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_buf[i] !== ref_mem[i]) begin
        errors++; $display("FAIL midrst_read byte %0d got %h want %h", i, rd_buf[i], ref_mem[i]);
      end
    end
    sweep_mem("midrst_mem");
  endtask

  task automatic test_random();
    logic [23:0] a;
    logic [7:0]  d [$];
    int          n;
    for (int t = 0; t < 24; t++) begin
      a = 24'($urandom);
      n = int'($urandom_range(1, 5));
      if ($urandom_range(0, 1) == 1) begin
        d.delete();
        for (int i = 0; i < n; i++) d.push_back(8'($urandom));
        spi_write(a, d);
        daddr = 24'($urandom);
        #1;
        checks++;
        if (ddata !== ref_debug(daddr)) begin
          errors++; $display("FAIL rand_debug addr %h got %h want %h", daddr, ddata, ref_debug(daddr));
        end
      end else begin
        spi_read(a, n);
        for (int i = 0; i < n; i++) begin
          checks++;
          if (rd_buf[i] !== ref_mem[(int'(a) + i) % DEPTH]) begin
            errors++; $display("FAIL rand_read addr %h byte %0d got %h want %h", a, i, rd_buf[i], ref_mem[(int'(a) + i) % DEPTH]);
          end
        end
        checks++;
        if (pre_nz !== 1'b0) begin errors++; $display("FAIL rand_hdr_miso got %b want 0", pre_nz); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] a;
    a = 24'($urandom);
    spi_write(a, '{8'($urandom), 8'($urandom), 8'($urandom)});
    spi_read(a, 3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_buf[i] !== ref_mem[(int'(a) + i) % DEPTH]) begin
        errors++; $display("FAIL b2b_read byte %0d got %h want %h", i, rd_buf[i], ref_mem[(int'(a) + i) % DEPTH]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    rst = 1'b1; sel = 1'b0; mosi = 1'b0; daddr = '0;
    test_reset();
    test_write_init();
    test_read_basic();
    test_write_readback();
    test_wrap();
    test_ignore();
    test_partial();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
